// File: rtl/aes_state_share_gen.sv
// rtl/aes_state_share_gen.sv - two-share masked state generator feeding the AES cipher core
module aes_state_share_gen #(
  parameter int unsigned EntropyWidth = 32,
  parameter int unsigned DataWidth    = 128
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    force_masks_i,
  input  logic                    data_in_valid_i,
  output logic                    data_in_ready_o,
  input  logic [DataWidth-1:0]    data_in_i,
  output logic                    entropy_req_o,
  input  logic                    entropy_ack_i,
  input  logic [EntropyWidth-1:0] entropy_i,
  output logic                    share_valid_o,
  input  logic                    share_ready_i,
  output logic [2*DataWidth-1:0]  state_init_o,
  output logic                    busy_o
);

  localparam int unsigned NumWords = DataWidth / EntropyWidth;
  localparam int unsigned CntW     = (NumWords > 1) ? $clog2(NumWords) : 1;

  if (DataWidth != 128) begin : gen_bad_data_width
    $error("aes_state_share_gen: DataWidth must be 128");
  end
  if (!(EntropyWidth inside {8, 16, 32, 64, 128})) begin : gen_bad_entropy_width
    $error("aes_state_share_gen: EntropyWidth must be one of 8/16/32/64/128");
  end

  typedef enum logic {
    StFetch = 1'b0,
    StReady = 1'b1
  } state_e;

  state_e                 state_q;
  logic [DataWidth-1:0]   mask_q;
  logic                   mask_valid_q;
  logic [CntW-1:0]        word_cnt_q;
  logic                   share_valid_q;
  logic [2*DataWidth-1:0] state_init_q;
  logic                   accept;

  // Request entropy whenever the mask is being (re)built; held low while in reset.
  assign entropy_req_o   = rst_ni & (state_q == StFetch);
  // Only a complete mask may be combined with data, and never in a clear cycle.
  assign data_in_ready_o = (state_q == StReady) & mask_valid_q & ~clear_i &
                           (~share_valid_q | share_ready_i);
  assign accept          = data_in_valid_i & data_in_ready_o;
  assign share_valid_o   = share_valid_q;
  assign state_init_o    = state_init_q;
  assign busy_o          = (state_q == StFetch) | share_valid_q;

  // Mask fetch FSM plus the single-entry output slot; clear wins over everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StFetch;
      mask_q        <= '0;
      mask_valid_q  <= 1'b0;
      word_cnt_q    <= '0;
      share_valid_q <= 1'b0;
      state_init_q  <= '0;
    end else if (clear_i) begin
      state_q       <= StFetch;
      mask_q        <= '0;
      mask_valid_q  <= 1'b0;
      word_cnt_q    <= '0;
      share_valid_q <= 1'b0;
      state_init_q  <= '0;
    end else begin
      // The slot is reloaded on accept even when it drains in the same cycle.
      if (accept) begin
        share_valid_q <= 1'b1;
        state_init_q  <= {mask_q, data_in_i ^ mask_q};
      end else if (share_ready_i) begin
        share_valid_q <= 1'b0;
      end

      case (state_q)
        StFetch: begin
          if (entropy_req_o && entropy_ack_i) begin
            for (int unsigned w = 0; w < NumWords; w++) begin
              if (word_cnt_q == CntW'(w)) begin
                mask_q[w*EntropyWidth +: EntropyWidth] <= entropy_i;
              end
            end
            if (word_cnt_q == CntW'(NumWords - 1)) begin
              mask_valid_q <= 1'b1;
              word_cnt_q   <= '0;
              state_q      <= StReady;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        StReady: begin
          // A forced mask is reused for the next block; otherwise refetch.
          if (accept && !force_masks_i) begin
            mask_valid_q <= 1'b0;
            state_q      <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_state_share_gen.sv
// tb/tb_aes_state_share_gen.sv - directed scoreboard bench for aes_state_share_gen
module tb_aes_state_share_gen;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         clear_i;
  logic         force_masks_i;
  logic         data_in_valid_i;
  logic         data_in_ready_o;
  logic [127:0] data_in_i;
  logic         entropy_req_o;
  logic         entropy_ack_i;
  logic [31:0]  entropy_i;
  logic         share_valid_o;
  logic         share_ready_i;
  logic [255:0] state_init_o;
  logic         busy_o;

  int vectors     = 0;
  int miscompares = 0;
  logic [255:0] sb[$];

  aes_state_share_gen #(.EntropyWidth(32), .DataWidth(128)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .force_masks_i   (force_masks_i),
    .data_in_valid_i (data_in_valid_i),
    .data_in_ready_o (data_in_ready_o),
    .data_in_i       (data_in_i),
    .entropy_req_o   (entropy_req_o),
    .entropy_ack_i   (entropy_ack_i),
    .entropy_i       (entropy_i),
    .share_valid_o   (share_valid_o),
    .share_ready_i   (share_ready_i),
    .state_init_o    (state_init_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Settle, retire any output handshake against the scoreboard, advance one clock.
  task automatic step();
    logic [255:0] e;
    #1;
    if (share_valid_o && share_ready_i) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL sb_unexpected_output observed=%0h expected=none", state_init_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("state_init", state_init_o, e);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  // Deliver a full mask back-to-back, lowest word first.
  task automatic fill(input logic [127:0] m);
    for (int k = 0; k < 4; k++) begin
      entropy_ack_i = 1'b1;
      entropy_i     = m[k*32 +: 32];
      #1;
      check("fill_req", entropy_req_o, 1'b1);
      check("fill_ready", data_in_ready_o, 1'b0);
      step();
    end
    entropy_ack_i = 1'b0;
    entropy_i     = '0;
  endtask

  localparam logic [127:0] M1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] M2 = 128'h0BADF00D_CAFEBABE_12345678_9ABCDEF0;
  localparam logic [127:0] D2 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
  localparam logic [127:0] M3 = 128'hC0DE0004_C0DE0003_C0DE0002_C0DE0001;
  localparam logic [127:0] M5 = 128'h55550004_55550003_55550002_55550001;
  localparam logic [127:0] D5 = 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978;
  localparam logic [127:0] M6 = 128'h66660004_66660003_66660002_66660001;
  localparam logic [127:0] D6 = 128'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F;

  initial begin
    logic [6:0]   pat;
    logic [127:0] dq;
    int           k;

    rst_ni = 1'b0; clear_i = 1'b0; force_masks_i = 1'b0;
    data_in_valid_i = 1'b0; data_in_i = '0;
    entropy_ack_i = 1'b0; entropy_i = '0; share_ready_i = 1'b0;

    // Reset values
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready", data_in_ready_o, 1'b0);
    check("rst_req", entropy_req_o, 1'b0);
    check("rst_share_valid", share_valid_o, 1'b0);
    check("rst_state_init", state_init_o, '0);
    rst_ni = 1'b1;
    #1;
    check("post_rst_req", entropy_req_o, 1'b1);
    check("post_rst_busy", busy_o, 1'b1);
    check("post_rst_ready", data_in_ready_o, 1'b0);

    // Basic fill
    fill(M1);
    #1;
    check("fill_req_drop", entropy_req_o, 1'b0);
    check("fill_ready_up", data_in_ready_o, 1'b1);
    check("idle_busy", busy_o, 1'b0);

    // Single block, held in the slot
    data_in_valid_i = 1'b1; data_in_i = D1;
    #1;
    check("blk1_ready", data_in_ready_o, 1'b1);
    sb.push_back({M1, D1 ^ M1});
    step();
    data_in_valid_i = 1'b0;
    #1;
    check("blk1_valid", share_valid_o, 1'b1);
    check("blk1_req", entropy_req_o, 1'b1);
    check("blk1_busy", busy_o, 1'b1);
    check("blk1_share1", state_init_o[255:128], M1);
    check("blk1_unmask", state_init_o[127:0] ^ state_init_o[255:128], D1);
    check("blk1_slot", state_init_o, sb[0]);

    // Backpressure while the next mask completes with gaps
    k = 0;
    for (int c = 0; c < 10; c++) begin
      entropy_ack_i = (c % 2 == 0) && (k < 4);
      entropy_i     = entropy_ack_i ? M2[k*32 +: 32] : 32'hBAD0BAD0;
      #1;
      check("stall_hold", state_init_o, sb[0]);
      check("stall_ready", data_in_ready_o, 1'b0);
      step();
      if (entropy_ack_i) k++;
    end
    entropy_ack_i = 1'b0;
    #1;
    check("stall_req_done", entropy_req_o, 1'b0);
    share_ready_i = 1'b1; data_in_valid_i = 1'b1; data_in_i = D2;
    #1;
    check("b2b_ready", data_in_ready_o, 1'b1);
    sb.push_back({M2, D2 ^ M2});
    step();
    data_in_valid_i = 1'b0;
    #1;
    check("b2b_valid", share_valid_o, 1'b1);
    check("b2b_slot", state_init_o, sb[0]);
    step();
    check("drain_valid", share_valid_o, 1'b0);

    // Entropy gaps: ack pattern 1,0,0,1,0,1,1; unacked words are junk
    pat = 7'b1101001;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      entropy_ack_i = pat[i];
      entropy_i     = pat[i] ? M3[k*32 +: 32] : 32'hDEADBEEF;
      #1;
      check("gap_req", entropy_req_o, 1'b1);
      check("gap_ready", data_in_ready_o, 1'b0);
      step();
      if (pat[i]) k++;
    end
    entropy_ack_i = 1'b0;
    #1;
    check("gap_ready_up", data_in_ready_o, 1'b1);

    // Forced mask over three blocks
    force_masks_i = 1'b1; share_ready_i = 1'b1; entropy_ack_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      dq = {4{32'h01010101 * (b + 7)}};
      data_in_valid_i = 1'b1; data_in_i = dq;
      #1;
      check("force_ready", data_in_ready_o, 1'b1);
      check("force_req", entropy_req_o, 1'b0);
      sb.push_back({M3, dq ^ M3});
      step();
    end
    data_in_valid_i = 1'b0; entropy_ack_i = 1'b0;
    #1;
    check("force_req_after", entropy_req_o, 1'b0);
    check("force_still_ready", data_in_ready_o, 1'b1);
    step();

    // Clear mid-fetch with a pending output
    force_masks_i = 1'b0; share_ready_i = 1'b0;
    data_in_valid_i = 1'b1; data_in_i = D2;
    sb.push_back({M3, D2 ^ M3});
    step();
    data_in_valid_i = 1'b0;
    entropy_ack_i = 1'b1; entropy_i = 32'hEEEE0001; step();
    entropy_i = 32'hEEEE0002; step();
    clear_i = 1'b1; entropy_i = 32'hEEEE0003;
    #1;
    check("clr1_ready", data_in_ready_o, 1'b0);
    step();
    void'(sb.pop_back());
    clear_i = 1'b0; entropy_ack_i = 1'b0;
    #1;
    check("clr1_valid", share_valid_o, 1'b0);
    check("clr1_state", state_init_o, '0);
    check("clr1_req", entropy_req_o, 1'b1);
    fill(M5);
    #1;
    check("clr1_refill_ready", data_in_ready_o, 1'b1);
    force_masks_i = 1'b1; data_in_valid_i = 1'b1; data_in_i = D5;
    sb.push_back({M5, D5 ^ M5});
    step();
    #1;
    check("post_clear_mask", state_init_o, sb[0]);

    // Clear while the slot is full and an input is offered
    clear_i = 1'b1;
    #1;
    check("clr2_ready", data_in_ready_o, 1'b0);
    step();
    void'(sb.pop_back());
    clear_i = 1'b0; data_in_valid_i = 1'b0; force_masks_i = 1'b0;
    #1;
    check("clr2_valid", share_valid_o, 1'b0);
    check("clr2_state", state_init_o, '0);
    check("clr2_req", entropy_req_o, 1'b1);
    check("clr2_busy", busy_o, 1'b1);

    // Recovery after clear
    fill(M6);
    share_ready_i = 1'b1; data_in_valid_i = 1'b1; data_in_i = D6;
    #1;
    check("final_ready", data_in_ready_o, 1'b1);
    sb.push_back({M6, D6 ^ M6});
    step();
    data_in_valid_i = 1'b0;
    step();
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_state_share_gen.md
Name: aes_state_share_gen

Overview:
- Upstream feeder for aes_cipher_core in masked configurations.
- Accepts unmasked 128-bit blocks and fetches fresh 128-bit masks from the 32-bit EDN-style entropy interface.
- Produces the two-share state_init vector consumed by the cipher core: share0 = data ^ mask, share1 = mask.
- Uses a single-bit valid/ready handshake on both sides and buffers one output block.

Parameters:
- EntropyWidth, 32, width of one entropy word; legal values 8/16/32/64/128; NumWords = 128/EntropyWidth.
- DataWidth, 128, block width; fixed at 128, with an elaboration error otherwise.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- clear_i  in  1  synchronous clear: flush the output slot and discard the current mask
- force_masks_i  in  1  keep the current mask for the next block; used for SCA evaluation
- data_in_valid_i  in  1  input block valid
- data_in_ready_o  out  1  input block ready
- data_in_i  in  128  unmasked block
- entropy_req_o  out  1  entropy request
- entropy_ack_i  in  1  entropy word valid; a transfer occurs on req & ack
- entropy_i  in  EntropyWidth  entropy word
- share_valid_o  out  1  output shares valid
- share_ready_i  in  1  output shares accepted
- state_init_o  out  256  [127:0] = share0 = data ^ mask; [255:128] = share1 = mask
- busy_o  out  1  mask fetch in progress or output slot occupied

Behaviour:
- Reset is asynchronous, active-low, on rst_ni; clock is clk_i.
- Reset values:
  - data_in_ready_o = 0, entropy_req_o = 0, share_valid_o = 0, state_init_o = 0.
  - Internal mask register = 0, mask_valid = 0, word_cnt = 0.
  - FSM = FETCH. busy_o = 1 from the first cycle after reset.
- FSM states:
  - FETCH: entropy_req_o = 1. Each cycle with entropy_req_o & entropy_ack_i writes entropy_i into mask[word_cnt*EntropyWidth +: EntropyWidth] and increments word_cnt.
    - On the transfer with word_cnt == NumWords-1: set mask_valid = 1, clear word_cnt, go to READY.
    - entropy_req_o is combinational from state; it is 0 in the cycle after the last word.
  - READY: mask_valid = 1. data_in_ready_o = !clear_i & (!share_valid_o | share_ready_i).
    - On accept (valid & ready): register share0/share1 into state_init_o and set share_valid_o = 1 next cycle (latency 1).
    - If force_masks_i = 0 at accept: clear mask_valid and go to FETCH.
    - If force_masks_i = 1 at accept: stay in READY and keep the mask.
- data_in_ready_o is 0 in FETCH.
- Output slot:
  - share_valid_o falls after a cycle with share_valid_o & share_ready_i unless a new block is accepted in the same cycle. That case is back-to-back: the slot is reloaded and share_valid_o stays 1.
  - state_init_o holds stable while share_valid_o = 1 and share_ready_i = 0.
- Mask fetch overlaps with a pending output. FETCH runs regardless of the output slot state.
- clear_i (highest priority, takes effect next cycle):
  - share_valid_o = 0, state_init_o = 0, mask = 0, mask_valid = 0, word_cnt = 0, FSM = FETCH.
  - An entropy word acked in a clear cycle is discarded.
  - An input offered in a clear cycle is not accepted (ready forced 0).
- busy_o = (FSM == FETCH) | share_valid_o.
- Handshake rule: state_init_o never combines data with a mask word fetched after the data was accepted. Each block sees exactly the mask that was complete at its accept cycle.
- Reset mid-fetch discards the partial mask. Fetch restarts at word 0 after reset release.

Test Plan:
- Basic fill: after reset, ack 4 words 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back -> entropy_req_o drops after the 4th ack; data_in_ready_o = 1 the following cycle; share1 = 0x44444444_33333333_22222222_11111111.
- Single block: with that mask, offer data_in_i = 0x00112233_44556677_8899AABB_CCDDEEFF -> share_valid_o = 1 one cycle after accept; share0 = data ^ mask; share0 ^ share1 == data; entropy_req_o = 1 in the same cycle.
- Stall/backpressure: share_ready_i = 0 for 10 cycles while a new mask completes -> state_init_o stable; data_in_ready_o = 0 until share_ready_i = 1. Then a back-to-back accept keeps share_valid_o high and loads the second block with the second mask.
- Entropy gaps: ack pattern 1,0,0,1,0,1,1 -> mask word order correct; word_cnt never skips; ready only after the 4th transfer.
- force_masks_i = 1 over 3 blocks -> no entropy requests; all three outputs carry an identical share1.
- clear_i asserted after 2 of 4 words and again while share_valid_o = 1 -> share_valid_o = 0 and state_init_o = 0 next cycle. Fetch restarts at word 0, and the next mask consists only of post-clear words.
